display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_pkg.sv | 50 +++++
 rtl/seg2_encoder.sv | 32 +++
 rtl/display_scheduler.sv | 129 ++++++++++++
 tb/tb_display_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display scheduler.
//
// Contents:
//   state_e     - scheduler FSM states (IDLE, SHOW0, SHOW1)
//   SEG_BLANK   - all segments off (active-low)
//   SEG_0..9    - active-low 7-segment codes, segment order a..g, MSB = a
//   DISP_BLANK  - both digits blank
//   digit_code  - maps a decimal digit 0..9 to its segment code
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  localparam logic [13:0] DISP_BLANK = 14'h3FFF;

  // Digits above 9 never occur; they fall back to blank.
  function automatic logic [6:0] digit_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg2_encoder.sv
// Combinational two-digit decimal encoder for a 4-bit value.
//
// Ports:
//   value    in  [3:0]  unsigned 0..15
//   displays out [13:0] [13:7] tens digit, [6:0] units digit, active-low
//
// Build option: DISP_LEADING_ZERO_BLANK_EN blanks the tens digit for
// values 0..9; otherwise the tens digit shows 0.
module seg2_encoder
  import display_pkg::*;
(
  input  logic [3:0]  value,
  output logic [13:0] displays
);

  logic       ge_ten;
  logic [3:0] units;
  logic [6:0] tens_seg;

  // Range is 0..15, so the tens digit is either 0 or 1.
  assign ge_ten = (value >= 4'd10);
  assign units  = ge_ten ? (value - 4'd10) : value;

`ifdef DISP_LEADING_ZERO_BLANK_EN
  assign tens_seg = ge_ten ? SEG_1 : SEG_BLANK;
`else
  assign tens_seg = ge_ten ? SEG_1 : SEG_0;
`endif

  assign displays = {tens_seg, digit_code(units)};

endmodule

// File: rtl/display_scheduler.sv
// Two-requester display arbiter with minimum hold time.
//
// Parameters:
//   HOLD_CYCLES  minimum cycles a granted requester keeps the display (2..2^24)
// Ports:
//   clk       in        rising-edge clock
//   rst_n     in        asynchronous active-low reset
//   req       in  [1:0] per-requester request, bit k = requester k
//   val0      in  [3:0] requester 0 value
//   val1      in  [3:0] requester 1 value
//   gnt       out [1:0] one-hot registered grant, 00 when idle
//   displays  out [13:0] registered active-low 7-seg digits (tens, units)
//
// Handshake: req is a level; gnt follows one cycle after req is sampled.
// displays shows the value of the requester granted in the previous cycle,
// so it lags gnt by one cycle and follows live value changes.
//
// Build option: DISP_LEADING_ZERO_BLANK_EN (see seg2_encoder).
module display_scheduler
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [3:0]  val0,
  input  logic [3:0]  val1,
  output logic [1:0]  gnt,
  output logic [13:0] displays
);

  localparam logic [23:0] HOLD_MAX = 24'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [13:0] disp_q, disp_d;

  logic        own_req, oth_req;
  state_e      own_st, oth_st;
  logic [3:0]  enc_value;
  logic [13:0] enc_disp;

  // View the current SHOW state as "own" requester vs "other" requester.
  assign own_req = (state_q == SHOW1) ? req[1] : req[0];
  assign oth_req = (state_q == SHOW1) ? req[0] : req[1];
  assign own_st  = (state_q == SHOW1) ? SHOW1 : SHOW0;
  assign oth_st  = (state_q == SHOW1) ? SHOW0 : SHOW1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        case (req)
          2'b01:   state_d = SHOW0;
          2'b10:   state_d = SHOW1;
          2'b11:   state_d = last_q ? SHOW0 : SHOW1;
          default: state_d = IDLE;
        endcase
      end
      SHOW0, SHOW1: begin
        if (cnt_q < HOLD_MAX) begin
          // Still inside the hold window: the owner keeps it while requesting.
          if (own_req)      state_d = own_st;
          else if (oth_req) state_d = oth_st;
          else              state_d = IDLE;
        end else begin
          // Hold satisfied: a waiting requester takes over.
          if (oth_req)      state_d = oth_st;
          else if (own_req) state_d = own_st;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (state_d != state_q) begin
      cnt_d  = '0;
      last_d = (state_d == SHOW1);
    end else if (cnt_q != HOLD_MAX) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_comb begin
    case (state_d)
      SHOW0:   gnt_d = 2'b01;
      SHOW1:   gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
  end

  // The display reflects the requester owning the display this cycle.
  assign enc_value = (state_q == SHOW1) ? val1 : val0;

  seg2_encoder u_enc (
    .value    (enc_value),
    .displays (enc_disp)
  );

  assign disp_d = (state_q == IDLE) ? DISP_BLANK : enc_disp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      disp_q  <= DISP_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      disp_q  <= disp_d;
    end
  end

  assign gnt      = gnt_q;
  assign displays = disp_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler with HOLD_CYCLES = 4.
module tb_display_scheduler;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  val0;
  logic [3:0]  val1;
  logic [1:0]  gnt;
  logic [13:0] displays;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  display_scheduler #(.HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .val0     (val0),
    .val1     (val1),
    .gnt      (gnt),
    .displays (displays)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tbl [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010,
                                7'b0000110, 7'b1001100, 7'b0100100,
                                7'b0100000, 7'b0001111, 7'b0000000,
                                7'b0000100};

  function automatic logic [13:0] enc_m(input int v);
    logic [6:0] tens_seg;
    tens_seg = seg_tbl[v / 10];
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (v < 10) tens_seg = 7'b1111111;
`endif
    return {tens_seg, seg_tbl[v % 10]};
  endfunction

  // Who owns the display next cycle (-1 = nobody).
  function automatic int next_owner(input int owner, input int held,
                                    input logic [1:0] r, input int last);
    int o;
    if (owner < 0) begin
      if (r == 2'b00) return -1;
      if (r == 2'b01) return 0;
      if (r == 2'b10) return 1;
      return 1 - last;
    end
    o = 1 - owner;
    if (held < HOLD - 1) begin
      if (r[owner]) return owner;
      if (r[o])     return o;
      return -1;
    end
    if (r[o])     return o;
    if (r[owner]) return owner;
    return -1;
  endfunction

  function automatic int next_held(input int owner, input int nxt, input int held);
    if (nxt < 0 || nxt != owner) return 0;
    return (held + 1 > HOLD - 1) ? HOLD - 1 : held + 1;
  endfunction

  function automatic logic [1:0] owner_gnt(input int o);
    if (o < 0) return 2'b00;
    return (o == 0) ? 2'b01 : 2'b10;
  endfunction

  int          m_owner;
  int          m_held;
  int          m_last;
  logic [1:0]  exp_gnt;
  logic [13:0] exp_disp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  <= -1;
      m_held   <= 0;
      m_last   <= 1;
      exp_gnt  <= 2'b00;
      exp_disp <= 14'h3FFF;
    end else begin
      m_owner  <= next_owner(m_owner, m_held, req, m_last);
      m_held   <= next_held(m_owner, next_owner(m_owner, m_held, req, m_last), m_held);
      if (next_owner(m_owner, m_held, req, m_last) >= 0 &&
          next_owner(m_owner, m_held, req, m_last) != m_owner)
        m_last <= next_owner(m_owner, m_held, req, m_last);
      exp_gnt  <= owner_gnt(next_owner(m_owner, m_held, req, m_last));
      exp_disp <= (m_owner < 0) ? 14'h3FFF :
                  enc_m((m_owner == 0) ? int'(val0) : int'(val1));
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_gnt", {12'd0, gnt}, {12'd0, exp_gnt});
      chk("model_displays", displays, exp_disp);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [6:0] tens_zero;

  initial begin
`ifdef DISP_LEADING_ZERO_BLANK_EN
    tens_zero = 7'b1111111;
`else
    tens_zero = 7'b0000001;
`endif
    rst_n = 1'b1;
    req   = 2'b00;
    val0  = 4'd0;
    val1  = 4'd0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    step(2);
    chk("reset_gnt", {12'd0, gnt}, 14'd0);
    chk("reset_displays", displays, 14'h3FFF);
    rst_n = 1'b1;
    step(1);
    chk("idle_gnt", {12'd0, gnt}, 14'd0);

    // Single requester, value 13 then 7.
    req = 2'b01; val0 = 4'd13;
    step(1);
    chk("single_gnt", {12'd0, gnt}, 14'b01);
    step(1);
    chk("single_disp_13", displays, {7'b1001111, 7'b0000110});
    val0 = 4'd7;
    step(1);
    chk("single_disp_7", displays, {tens_zero, 7'b0001111});
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_no_glitch", {12'd0, gnt}, 14'b01);
    end

    req = 2'b00;
    step(1);
    chk("release_gnt", {12'd0, gnt}, 14'd0);
    step(1);
    chk("release_disp", displays, 14'h3FFF);

    // Contention: last owner was 0, so requester 1 goes first.
    val0 = 4'd3; val1 = 4'd9; req = 2'b11;
    step(1);
    for (int i = 0; i < 12; i++) begin
      chk("contention_gnt", {12'd0, gnt}, ((i / 4) % 2 == 0) ? 14'b10 : 14'b01);
      step(1);
    end
    // Now in SHOW0 with counter 0; one more cycle gives counter 1.
    step(1);
    req = 2'b10;
    step(1);
    chk("early_switch_gnt", {12'd0, gnt}, 14'b10);
    req = 2'b00;
    step(1);
    chk("early_idle_gnt", {12'd0, gnt}, 14'd0);
    chk("early_idle_disp9", displays, {tens_zero, 7'b0000100});
    step(1);
    chk("early_idle_blank", displays, 14'h3FFF);

    // Asynchronous reset while SHOW1 is active.
    req = 2'b10;
    step(1);
    chk("pre_reset_gnt", {12'd0, gnt}, 14'b10);
    step(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_gnt", {12'd0, gnt}, 14'd0);
    chk("async_reset_disp", displays, 14'h3FFF);
    req = 2'b11;
    rst_n = 1'b1;
    step(1);
    chk("post_reset_tie", {12'd0, gnt}, 14'b01);

    // Encoder sweep on requester 0.
    req = 2'b01;
    for (int v = 0; v < 16; v++) begin
      val0 = 4'(v);
      step(1);
    end

    // Requester 1 value encoding.
    req = 2'b10; val1 = 4'd5;
    step(1);
    chk("val1_gnt", {12'd0, gnt}, 14'b10);
    step(1);
    chk("val1_disp5", displays, {tens_zero, 7'b0100100});
    val1 = 4'd15;
    step(1);
    chk("val1_disp15", displays, {7'b1001111, 7'b0100100});

    // Mixed traffic, checked by the model.
    for (int i = 0; i < 80; i++) begin
      req  = 2'($urandom_range(0, 3));
      val0 = 4'($urandom_range(0, 15));
      val1 = 4'($urandom_range(0, 15));
      step(1);
    end

    step(2);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
